cr_huf_comp_lut_pp_sched: RTL and testbench
===========================================

// Module: cr_huf_comp_lut_pp_sched
// PURPOSE
//  Ping-pong scheduler for the two short-symbol LUT banks (bank0/bank1) of the Huffman compressor.
//  Allocates a free bank to each new frame for the HW/ST writers and marks it FULL once both writers finish.
//  Presents FULL banks to the symbol assembler (SA) strictly in allocation order, and frees each bank on SA ret_ack.
//  Sits between the frame front-end, the HW/ST writers, the LUT pair and the SA.
// PARAMETERS
//  SEQID_W   6     width of frame sequence id
//  TMO_W     16    width of read-watchdog counter (used only with CR_HUF_COMP_LUT_SCHED_TMO_EN)
// PORTS
//  clk           in   1        core clock
//  rst           in   1        asynchronous, active-high reset
//  frm_req       in   1        front-end requests a bank for a new frame (level, held until frm_gnt)
//  frm_seq_id    in   SEQID_W  seq id of the requesting frame
//  frm_gnt       out  1        bank allocated this cycle (combinational from flops and frm_req)
//  wr_bank       out  1        bank currently in FILL (valid while wr_act=1)
//  wr_act        out  1        a bank is in FILL
//  hw_wr_done    in   1        HW writer finished current bank (1-cycle pulse)
//  st_wr_done    in   1        ST writer finished current bank (1-cycle pulse)
//  rd_vld        out  1        bank rd_bank is FULL and offered to SA
//  rd_bank       out  1        bank SA must read
//  rd_seq_id     out  SEQID_W  seq id stored for rd_bank
//  sa_ret_ack    in   1        SA releases rd_bank (1-cycle pulse)
//  bank_full     out  2        per-bank FULL|READ status (drives lutN_*_full)
//  proto_err     out  1        sticky: done pulse with no FILL bank, or ack with rd_vld=0
//  tmo_err       out  1        1-cycle pulse on read watchdog expiry (0 when feature compiled out)
// BEHAVIOUR
//  - Per-bank state: IDLE -> FILL (on grant) -> FULL (both dones seen) -> IDLE (on ack while rd_vld).
//  - Reset: both banks IDLE, wr_ptr=0, rd_ptr=0, done flags 0, seq regs 0; all outputs 0.
//  - frm_gnt = frm_req & !wr_act & state[wr_ptr]==IDLE. On grant: state[wr_ptr]<=FILL, seq[wr_ptr]<=frm_seq_id, wr_ptr toggles.
//  - At most one bank is in FILL at a time. wr_bank = index of the FILL bank.
//  - Done flags hw_seen/st_seen are set by the done pulses; the dones may arrive in either order or in the same cycle.
//  - When both flags are set (including the pulse this cycle), the FILL bank becomes FULL on the next edge and both flags clear.
//  - Latency: last done at cycle t -> bank_full/rd_vld high at t+1, provided the bank is at rd_ptr.
//  - rd_vld = state[rd_ptr]==FULL. rd_bank = rd_ptr. rd_seq_id = seq[rd_ptr].
//  - Order: banks are read in grant order, never by seq-id value.
//  - sa_ret_ack while rd_vld: state[rd_ptr]<=IDLE and rd_ptr toggles. If the other bank is FULL, rd_vld stays high next cycle with the new bank.
//  - A bank freed by ack in cycle t is grantable at t+1 at the earliest. There is no same-cycle bypass.
//  - Grant and ack in the same cycle act on different banks and both take effect.
//  - Both banks FULL/READ: frm_gnt held 0 and frm_req waits.
//  - Error cases:
//    - done pulse while !wr_act: ignored, proto_err<=1.
//    - sa_ret_ack while !rd_vld: ignored, proto_err<=1.
//    - Duplicate done before the bank goes FULL: no effect on state.
//  - rst asserted mid-frame: all state is discarded immediately. Writers and SA are reset on the same rst.
// CONFIGURATION
//  CR_HUF_COMP_LUT_SCHED_TMO_EN defined:
//    - TMO_W counter clears on !rd_vld or ack, and increments while rd_vld & !ack.
//    - At all-ones it saturates and tmo_err pulses once; the next pulse needs a fresh rd_vld episode.
//    - Scheduling is unaffected.
//  Not defined: no counter, tmo_err tied 0.
// STRUCTURE
//  - cr_huf_compPKG: typedef enum logic[1:0] {LUT_IDLE,LUT_FILL,LUT_FULL} e_lut_bank_st; localparam CREOLE_HC_LUT_BANKS=2.
//  - Sub-module cr_huf_comp_lut_bank_fsm (state + seq register, x2), with inputs grant/fill_done/ack.
//  - Pointers, done flags, errors and watchdog live in the top.
// TESTING
//  1 frm_req seq=5; hw_done t=10, st_done t=12 -> frm_gnt, wr_bank=0; rd_vld=1 rd_bank=0 rd_seq_id=5 at t=13.
//  2 hw_done and st_done in the same cycle t -> bank FULL at t+1; flags clear; a second frame is granted bank1.
//  3 Grant seq=1,2, both filled; req seq=3 -> no gnt until ack bank0; gnt at ack+1 on bank0; reads order 1,2,3.
//  4 st_done with wr_act=0; ack with rd_vld=0 -> no state change, proto_err=1 and held until rst.
//  5 rst asserted during FILL with hw_seen=1 -> all outputs 0 next sample; new frame granted bank0.
//  6 TMO_EN, TMO_W=4: rd_vld held without ack -> tmo_err 1-cycle pulse after 15 cycles; ack clears the counter.

Source files
------------

// File: rtl/cr_huf_comp_lut_pp_sched_pkg.sv
// Shared types and constants for the short-symbol LUT ping-pong scheduler.
package cr_huf_comp_lut_pp_sched_pkg;

  localparam int unsigned CREOLE_HC_LUT_BANKS = 2;

  typedef enum logic [1:0] {
    LUT_IDLE = 2'd0,
    LUT_FILL = 2'd1,
    LUT_FULL = 2'd2
  } e_lut_bank_st;

  function automatic logic is_full(input e_lut_bank_st s);
    return s == LUT_FULL;
  endfunction

  function automatic logic is_fill(input e_lut_bank_st s);
    return s == LUT_FILL;
  endfunction

  function automatic logic is_idle(input e_lut_bank_st s);
    return s == LUT_IDLE;
  endfunction

endpackage

// File: rtl/cr_huf_comp_lut_pp_sched_if.sv
// Handshake bundle between the scheduler and front-end / writers / SA.
interface cr_huf_comp_lut_pp_sched_if #(
  parameter int unsigned SEQID_W = 6
) ();

  logic               frm_req;
  logic [SEQID_W-1:0] frm_seq_id;
  logic               frm_gnt;
  logic               wr_bank;
  logic               wr_act;
  logic               hw_wr_done;
  logic               st_wr_done;
  logic               rd_vld;
  logic               rd_bank;
  logic [SEQID_W-1:0] rd_seq_id;
  logic               sa_ret_ack;
  logic [1:0]         bank_full;
  logic               proto_err;
  logic               tmo_err;

  // Environment side: front-end, writers and SA.
  modport master (
    output frm_req, frm_seq_id, hw_wr_done, st_wr_done, sa_ret_ack,
    input  frm_gnt, wr_bank, wr_act, rd_vld, rd_bank, rd_seq_id,
           bank_full, proto_err, tmo_err
  );

  // Scheduler side.
  modport slave (
    input  frm_req, frm_seq_id, hw_wr_done, st_wr_done, sa_ret_ack,
    output frm_gnt, wr_bank, wr_act, rd_vld, rd_bank, rd_seq_id,
           bank_full, proto_err, tmo_err
  );

endinterface

// File: rtl/cr_huf_comp_lut_bank_fsm.sv
// Per-bank lifecycle IDLE -> FILL -> FULL -> IDLE plus the seq id captured at grant.
module cr_huf_comp_lut_bank_fsm
  import cr_huf_comp_lut_pp_sched_pkg::*;
#(
  parameter int unsigned SEQID_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               grant,
  input  logic               fill_done,
  input  logic               ack,
  input  logic [SEQID_W-1:0] seq_in,
  output e_lut_bank_st       st,
  output logic [SEQID_W-1:0] seq
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st  <= LUT_IDLE;
      seq <= '0;
    end else begin
      case (st)
        LUT_IDLE: if (grant) begin
          st  <= LUT_FILL;
          seq <= seq_in;
        end
        LUT_FILL: if (fill_done) st <= LUT_FULL;
        LUT_FULL: if (ack)       st <= LUT_IDLE;
        default:                 st <= LUT_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/cr_huf_comp_lut_pp_sched.sv
// Ping-pong scheduler for the two short-symbol LUT banks.
// Optional read watchdog enabled by defining CR_HUF_COMP_LUT_SCHED_TMO_EN.
module cr_huf_comp_lut_pp_sched
  import cr_huf_comp_lut_pp_sched_pkg::*;
#(
  parameter int unsigned SEQID_W = 6,
  parameter int unsigned TMO_W   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  cr_huf_comp_lut_pp_sched_if.slave   bus
);

  localparam int unsigned NB = CREOLE_HC_LUT_BANKS;

  e_lut_bank_st       st  [NB];
  logic [SEQID_W-1:0] seq [NB];

  logic [NB-1:0] fill_c, full_c, gnt_v_c, done_v_c, ack_v_c;
  logic          wr_ptr, rd_ptr;
  logic          hw_seen, st_seen, proto_err_q;
  logic          wr_act_c, rd_vld_c, gnt_c, hw_all_c, st_all_c, fill_done_c, ack_ok_c;

  // Status decode and per-bank command fan-out.
  always_comb begin
    fill_c   = '0;
    full_c   = '0;
    gnt_v_c  = '0;
    done_v_c = '0;
    ack_v_c  = '0;
    for (int i = 0; i < int'(NB); i++) begin
      fill_c[i] = is_fill(st[i]);
      full_c[i] = is_full(st[i]);
    end
    wr_act_c    = |fill_c;
    rd_vld_c    = full_c[rd_ptr];
    gnt_c       = bus.frm_req & ~wr_act_c & is_idle(st[wr_ptr]);
    hw_all_c    = hw_seen | bus.hw_wr_done;
    st_all_c    = st_seen | bus.st_wr_done;
    fill_done_c = wr_act_c & hw_all_c & st_all_c;
    ack_ok_c    = bus.sa_ret_ack & rd_vld_c;
    for (int i = 0; i < int'(NB); i++) begin
      gnt_v_c[i]  = gnt_c & (wr_ptr == 1'(i));
      done_v_c[i] = fill_done_c & fill_c[i];
      ack_v_c[i]  = ack_ok_c & (rd_ptr == 1'(i));
    end
  end

  for (genvar b = 0; b < int'(NB); b++) begin : g_bank
    cr_huf_comp_lut_bank_fsm #(.SEQID_W(SEQID_W)) u_bank (
      .clk       (clk),
      .rst       (rst),
      .grant     (gnt_v_c[b]),
      .fill_done (done_v_c[b]),
      .ack       (ack_v_c[b]),
      .seq_in    (bus.frm_seq_id),
      .st        (st[b]),
      .seq       (seq[b])
    );
  end

  // Pointers, writer-done flags and sticky protocol error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      hw_seen     <= 1'b0;
      st_seen     <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      if (gnt_c)    wr_ptr <= ~wr_ptr;
      if (ack_ok_c) rd_ptr <= ~rd_ptr;
      if (fill_done_c) begin
        hw_seen <= 1'b0;
        st_seen <= 1'b0;
      end else if (wr_act_c) begin
        hw_seen <= hw_all_c;
        st_seen <= st_all_c;
      end
      if (((bus.hw_wr_done | bus.st_wr_done) & ~wr_act_c) |
          (bus.sa_ret_ack & ~rd_vld_c))
        proto_err_q <= 1'b1;
    end
  end

  assign bus.frm_gnt   = gnt_c;
  assign bus.wr_act    = wr_act_c;
  assign bus.wr_bank   = fill_c[1];
  assign bus.rd_vld    = rd_vld_c;
  assign bus.rd_bank   = rd_ptr;
  assign bus.rd_seq_id = seq[rd_ptr];
  assign bus.bank_full = full_c;
  assign bus.proto_err = proto_err_q;

`ifdef CR_HUF_COMP_LUT_SCHED_TMO_EN
  localparam logic [TMO_W-1:0] TMO_MAX = '1;

  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_q;

  // Watchdog: one pulse per rd_vld episode when the SA stalls too long.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
      tmo_q   <= 1'b0;
    end else if (!rd_vld_c || bus.sa_ret_ack) begin
      tmo_cnt <= '0;
      tmo_q   <= 1'b0;
    end else begin
      if (tmo_cnt != TMO_MAX) tmo_cnt <= tmo_cnt + TMO_W'(1);
      tmo_q <= (tmo_cnt == TMO_MAX - TMO_W'(1));
    end
  end

  assign bus.tmo_err = tmo_q;
`else
  logic [TMO_W-1:0] unused_tmo_c;
  assign unused_tmo_c = '0;
  assign bus.tmo_err  = 1'b0;
`endif

endmodule

// File: tb/tb_cr_huf_comp_lut_pp_sched.sv
// Directed bench for cr_huf_comp_lut_pp_sched; watchdog checks follow CR_HUF_COMP_LUT_SCHED_TMO_EN.
module tb_cr_huf_comp_lut_pp_sched;

`ifdef CR_HUF_COMP_LUT_SCHED_TMO_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  cr_huf_comp_lut_pp_sched_if #(.SEQID_W(6)) bus ();

  cr_huf_comp_lut_pp_sched #(.SEQID_W(6), .TMO_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic req, input logic [5:0] sid, input logic hw,
                       input logic st, input logic ack);
    bus.frm_req    = req;
    bus.frm_seq_id = sid;
    bus.hw_wr_done = hw;
    bus.st_wr_done = st;
    bus.sa_ret_ack = ack;
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},  32'(bus.frm_gnt),   0);
    chk({tag, "_wact"}, 32'(bus.wr_act),    0);
    chk({tag, "_wbk"},  32'(bus.wr_bank),   0);
    chk({tag, "_rvld"}, 32'(bus.rd_vld),    0);
    chk({tag, "_rbk"},  32'(bus.rd_bank),   0);
    chk({tag, "_rsid"}, 32'(bus.rd_seq_id), 0);
    chk({tag, "_full"}, 32'(bus.bank_full), 0);
    chk({tag, "_perr"}, 32'(bus.proto_err), 0);
    chk({tag, "_tmo"},  32'(bus.tmo_err),   0);
  endtask

  initial begin
    drive(0, 0, 0, 0, 0);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk_all_zero("rst");

    // 1: single frame, split dones
    drive(1, 5, 0, 0, 0); chk("t1_gnt", 32'(bus.frm_gnt), 1);
    tick(); drive(0, 0, 0, 0, 0);
    chk("t1_wact", 32'(bus.wr_act), 1); chk("t1_wbk", 32'(bus.wr_bank), 0);
    chk("t1_gnt_off", 32'(bus.frm_gnt), 0);
    tick(); drive(0, 0, 1, 0, 0); chk("t1_rvld_a", 32'(bus.rd_vld), 0);
    tick(); drive(0, 0, 0, 0, 0); chk("t1_rvld_b", 32'(bus.rd_vld), 0);
    tick(); drive(0, 0, 0, 1, 0); chk("t1_full_b", 32'(bus.bank_full), 0);
    tick(); drive(0, 0, 0, 0, 0);
    chk("t1_rvld", 32'(bus.rd_vld), 1); chk("t1_rbk", 32'(bus.rd_bank), 0);
    chk("t1_rsid", 32'(bus.rd_seq_id), 5); chk("t1_full", 32'(bus.bank_full), 1);
    chk("t1_wact_off", 32'(bus.wr_act), 0);
    drive(0, 0, 0, 0, 1);
    tick(); drive(0, 0, 0, 0, 0);
    chk("t1_ack_rvld", 32'(bus.rd_vld), 0); chk("t1_ack_rbk", 32'(bus.rd_bank), 1);
    chk("t1_ack_full", 32'(bus.bank_full), 0); chk("t1_perr", 32'(bus.proto_err), 0);

    // 2: same-cycle dones; grant and ack in the same cycle
    drive(1, 9, 0, 0, 0); chk("t2_gnt", 32'(bus.frm_gnt), 1);
    tick(); drive(0, 0, 1, 1, 0); chk("t2_wbk", 32'(bus.wr_bank), 1);
    tick(); drive(0, 0, 0, 0, 0);
    chk("t2_rvld", 32'(bus.rd_vld), 1); chk("t2_rbk", 32'(bus.rd_bank), 1);
    chk("t2_rsid", 32'(bus.rd_seq_id), 9); chk("t2_full", 32'(bus.bank_full), 2);
    chk("t2_wact", 32'(bus.wr_act), 0);
    drive(1, 10, 0, 0, 1); chk("t2_gnt2", 32'(bus.frm_gnt), 1);
    tick(); drive(0, 0, 0, 0, 0);
    chk("t2_wact2", 32'(bus.wr_act), 1); chk("t2_wbk2", 32'(bus.wr_bank), 0);
    chk("t2_rvld2", 32'(bus.rd_vld), 0); chk("t2_full2", 32'(bus.bank_full), 0);
    chk("t2_rbk2", 32'(bus.rd_bank), 0);
    drive(0, 0, 0, 1, 0);
    tick(); drive(0, 0, 0, 1, 0);
    tick(); drive(0, 0, 0, 0, 0);
    chk("t2_dup_rvld", 32'(bus.rd_vld), 0); chk("t2_dup_wact", 32'(bus.wr_act), 1);
    drive(0, 0, 1, 0, 0);
    tick(); drive(0, 0, 0, 0, 0);
    chk("t2_rvld3", 32'(bus.rd_vld), 1); chk("t2_rsid3", 32'(bus.rd_seq_id), 10);
    drive(0, 0, 0, 0, 1);
    tick(); drive(0, 0, 0, 0, 0);

    // 3: both banks full, request waits, reads in grant order
    drive(1, 1, 0, 0, 0); chk("t3_gnt1", 32'(bus.frm_gnt), 1);
    tick(); drive(0, 0, 1, 1, 0); chk("t3_wbk1", 32'(bus.wr_bank), 1);
    tick(); drive(1, 2, 0, 0, 0); chk("t3_gnt2", 32'(bus.frm_gnt), 1);
    tick(); drive(0, 0, 1, 1, 0); chk("t3_wbk2", 32'(bus.wr_bank), 0);
    tick(); drive(1, 3, 0, 0, 0);
    chk("t3_block", 32'(bus.frm_gnt), 0); chk("t3_full", 32'(bus.bank_full), 3);
    chk("t3_rbk1", 32'(bus.rd_bank), 1); chk("t3_rsid1", 32'(bus.rd_seq_id), 1);
    tick(); drive(1, 3, 0, 0, 1); chk("t3_block_ack", 32'(bus.frm_gnt), 0);
    tick(); drive(1, 3, 0, 0, 0);
    chk("t3_gnt3", 32'(bus.frm_gnt), 1); chk("t3_rvld2", 32'(bus.rd_vld), 1);
    chk("t3_rbk2", 32'(bus.rd_bank), 0); chk("t3_rsid2", 32'(bus.rd_seq_id), 2);
    tick(); drive(0, 0, 0, 0, 1);
    chk("t3_wbk3", 32'(bus.wr_bank), 1); chk("t3_wact3", 32'(bus.wr_act), 1);
    tick(); drive(0, 0, 1, 1, 0); chk("t3_rvld_gap", 32'(bus.rd_vld), 0);
    tick(); drive(0, 0, 0, 0, 0);
    chk("t3_rvld3", 32'(bus.rd_vld), 1); chk("t3_rsid3", 32'(bus.rd_seq_id), 3);
    chk("t3_rbk3", 32'(bus.rd_bank), 1); chk("t3_perr", 32'(bus.proto_err), 0);
    drive(0, 0, 0, 0, 1);
    tick(); drive(0, 0, 0, 0, 0);

    // 4: done pulse with no FILL bank
    drive(0, 0, 0, 1, 0);
    tick(); drive(0, 0, 0, 0, 0);
    chk("t4_perr_done", 32'(bus.proto_err), 1); chk("t4_wact", 32'(bus.wr_act), 0);
    chk("t4_full", 32'(bus.bank_full), 0);
    tick(); chk("t4_sticky", 32'(bus.proto_err), 1);

    // 5: reset mid-fill discards the seen flag
    drive(1, 7, 0, 0, 0); chk("t5_gnt", 32'(bus.frm_gnt), 1);
    tick(); drive(0, 0, 1, 0, 0);
    tick(); drive(0, 0, 0, 0, 0);
    rst = 1'b1; #1;
    chk_all_zero("t5_rst");
    tick(); rst = 1'b0; #1;
    drive(1, 4, 0, 0, 0); chk("t5_gnt2", 32'(bus.frm_gnt), 1);
    tick(); drive(0, 0, 0, 1, 0); chk("t5_wbk", 32'(bus.wr_bank), 0);
    tick(); drive(0, 0, 0, 0, 0); chk("t5_noflag", 32'(bus.rd_vld), 0);
    drive(0, 0, 1, 0, 0);
    tick(); drive(0, 0, 0, 0, 0);
    chk("t5_rvld", 32'(bus.rd_vld), 1); chk("t5_rsid", 32'(bus.rd_seq_id), 4);
    drive(0, 0, 0, 0, 1);
    tick(); drive(0, 0, 0, 0, 0);
    chk("t5_perr_clean", 32'(bus.proto_err), 0);

    // 4b: ack with nothing offered
    drive(0, 0, 0, 0, 1);
    tick(); drive(0, 0, 0, 0, 0);
    chk("t4_perr_ack", 32'(bus.proto_err), 1); chk("t4_rbk", 32'(bus.rd_bank), 1);
    chk("t4_rvld", 32'(bus.rd_vld), 0);

    // 6: watchdog, bank1 offered first (rd_ptr=1, wr_ptr=1)
    drive(1, 20, 0, 0, 0); chk("t6_gnt", 32'(bus.frm_gnt), 1);
    tick(); drive(0, 0, 1, 1, 0);
    tick(); drive(0, 0, 0, 0, 0);
    for (int i = 1; i <= 20; i++) begin
      drive(i == 1, 21, i == 2, i == 2, i == 20);
      chk($sformatf("t6_a_tmo%0d", i), 32'(bus.tmo_err), 32'(TMO_ON && i == 16));
      chk($sformatf("t6_a_rvld%0d", i), 32'(bus.rd_vld), 1);
      tick();
    end
    for (int j = 1; j <= 18; j++) begin
      drive(0, 0, 0, 0, j == 18);
      chk($sformatf("t6_b_tmo%0d", j), 32'(bus.tmo_err), 32'(TMO_ON && j == 16));
      chk($sformatf("t6_b_rsid%0d", j), 32'(bus.rd_seq_id), 21);
      tick();
    end
    drive(0, 0, 0, 0, 0);
    chk("t6_end_rvld", 32'(bus.rd_vld), 0); chk("t6_end_tmo", 32'(bus.tmo_err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
